piso_serializer: RTL
====================

# piso_serializer

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per shift strobe onto a single serial data line, together with a bit-valid qualifier. It is the driving end of the single-bit D-line capture used throughout the flip-flop experiments. A downstream D flip-flop chain clocked on `clk` and gated by `sdo_valid` reconstructs the word. It sits between a parallel data source (testbench or counter) and the serial line.

## Interface
- `WIDTH`, 8: bits per word; legal range 2–32.
- `LSB_FIRST`, 0: 0 = shift MSB first; 1 = shift LSB first.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `tx_data` input WIDTH: word to send; sampled only at the accept edge.
- `tx_valid` input 1: source has a word on `tx_data`.
- `tx_ready` output 1: block can accept a word this cycle.
- `shift_en` input 1: bit-rate strobe; the current bit advances only on edges where it is 1.
- `sdo` output 1: serial data out (the D line).
- `sdo_valid` output 1: `sdo` carries a frame bit.
- `done` output 1: one-cycle pulse after the last bit's shift edge.

## Operation
- Registers:
  - `shreg[WIDTH-1:0]`
  - `bitcnt`: $clog2(WIDTH+1) bits
  - `state`: IDLE, SHIFT, DONE
- All outputs are registered, with no combinational input-to-output path.
- Reset (edge with `rst_n`=0), regardless of state:
  - state=IDLE, `shreg`=0, `bitcnt`=0.
  - `tx_ready`=1, `sdo`=0, `sdo_valid`=0, `done`=0.
  - Any frame in progress is abandoned with no `done` pulse.
- IDLE:
  - `tx_ready`=1, `sdo_valid`=0, `sdo`=0.
  - On an edge with `tx_valid`=1 (accept), load `shreg`=`tx_data` and `bitcnt`=WIDTH-1, then go to SHIFT.
  - `shift_en` is ignored in IDLE.
- SHIFT:
  - `tx_ready`=0 and `sdo_valid`=1.
  - `sdo` = `shreg[WIDTH-1]` when MSB first, or `shreg[0]` when LSB first.
  - On an edge with `shift_en`=1 and `bitcnt`≠0: shift `shreg` by one toward the output end, fill with 0, and decrement `bitcnt`.
  - On an edge with `shift_en`=1 and `bitcnt`=0: go to DONE.
  - On an edge with `shift_en`=0: hold everything.
  - `tx_valid` is ignored. `tx_data` changes during SHIFT do not affect the frame.
- DONE (exactly one cycle):
  - `done`=1, `sdo_valid`=0, `sdo`=0, `tx_ready`=0.
  - Go to IDLE unconditionally.
- Each frame is exactly WIDTH bits. There is no start/stop bit and no parity.
- A `bitcnt` value above WIDTH-1 is unreachable; if it occurs, the next edge forces IDLE.

## Timing
- Accept edge T0: the edge where `tx_ready`=1 and `tx_valid`=1.
- Bit 0 appears on `sdo` with `sdo_valid`=1 in the cycle after T0.
- Each bit holds until the first subsequent edge with `shift_en`=1.
- With `shift_en` held at 1:
  - bit k is on `sdo` during cycle T0+1+k, for k = 0…WIDTH-1;
  - `done`=1 in cycle T0+WIDTH+1;
  - `tx_ready`=1 again in cycle T0+WIDTH+2.
- Minimum word-to-word spacing is WIDTH+2 cycles. Full throughput is not a goal.
- `shift_en` asserted on the accept edge does not shift; the first shift can occur at T0+1.
- If `rst_n`=0 coincides with an accept or shift edge, reset wins.
- If `tx_valid` is high during reset, the earliest accept is the first edge with `rst_n`=1.
- `tx_valid` may drop while `tx_ready`=0 with no effect.

## Test plan
- Reset value: hold `rst_n`=0 for 2 edges from any state, including mid-SHIFT after 3 bits. Required response:
  - `tx_ready`=1, `sdo`=0, `sdo_valid`=0, `done`=0 on the next cycle;
  - no `done` pulse afterward.
- MSB first: WIDTH=8, LSB_FIRST=0, `tx_data`=8'hA5, `shift_en`=1. Required response:
  - `sdo` reads 1,0,1,0,0,1,0,1 over 8 cycles with `sdo_valid`=1;
  - `done` pulses 9 cycles after accept;
  - `tx_ready` returns high 10 cycles after accept.
- LSB first: LSB_FIRST=1, `tx_data`=8'h3C. Required response:
  - `sdo` reads 0,0,1,1,1,1,0,0.
- Strobed rate: `shift_en` pulses every 4th cycle, `tx_data`=8'hF0. Required response:
  - each bit holds 4 cycles;
  - the frame spans 32 valid cycles;
  - the serial pattern is unchanged.
- Handshake: keep `tx_valid`=1 and change `tx_data` from 8'h81 to 8'h7E mid-frame. Required response:
  - the frame stays 8'h81;
  - the second word (8'h7E) is accepted only in the first IDLE cycle after `done`;
  - `tx_valid`=0 in IDLE gives no accept.
- WIDTH=2 corner, `tx_data`=2'b10. Required response:
  - `sdo` reads 1,0, then `done` pulses;
  - the receiving DFF chain samples 2'b10.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Parallel-word handshake plus serial-line bundle for piso_serializer.
// The master is the word source; the slave is the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             shift_en;
  logic             sdo;
  logic             sdo_valid;
  logic             done;

  modport master (
    output tx_data, tx_valid, shift_en,
    input  tx_ready, sdo, sdo_valid, done
  );

  modport slave (
    input  tx_data, tx_valid, shift_en,
    output tx_ready, sdo, sdo_valid, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per handshake, one bit per
// shift strobe, with every output registered from the next-state decode.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_serializer_if.slave   bus
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    w_bitcnt_next;
  logic             w_out_bit;

  logic r_tx_ready;
  logic r_sdo;
  logic r_sdo_valid;
  logic r_done;

  always_comb begin
    w_state_next  = r_state;
    w_shreg_next  = r_shreg;
    w_bitcnt_next = r_bitcnt;
    // An out-of-range count can only come from corruption; recover to IDLE.
    if (r_bitcnt > LAST) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.tx_valid) begin
            w_shreg_next  = bus.tx_data;
            w_bitcnt_next = LAST;
            w_state_next  = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            if (r_bitcnt == '0) begin
              w_state_next = DONE;
            end else begin
              w_shreg_next  = LSB_FIRST ? {1'b0, r_shreg[WIDTH-1:1]}
                                        : {r_shreg[WIDTH-2:0], 1'b0};
              w_bitcnt_next = r_bitcnt - 1'b1;
            end
          end
        end
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
    w_out_bit = LSB_FIRST ? w_shreg_next[0] : w_shreg_next[WIDTH-1];
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_tx_ready  <= 1'b1;
      r_sdo       <= 1'b0;
      r_sdo_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shreg     <= w_shreg_next;
      r_bitcnt    <= w_bitcnt_next;
      r_tx_ready  <= (w_state_next == IDLE);
      r_sdo_valid <= (w_state_next == SHIFT);
      r_sdo       <= (w_state_next == SHIFT) && w_out_bit;
      r_done      <= (w_state_next == DONE);
    end
  end

  assign bus.tx_ready  = r_tx_ready;
  assign bus.sdo       = r_sdo;
  assign bus.sdo_valid = r_sdo_valid;
  assign bus.done      = r_done;

endmodule
